dac_spi_serializer: RTL and testbench

- Downstream stage of the waveform compute block. Consumes each 16-bit signed sample on the compute block's `result` output.
- Converts the sample to DAC code: two's complement to offset binary, when enabled.
- Shifts the code MSB-first to an external serial DAC over an SPI mode-0 link (`dac_sclk`, `dac_mosi`, `dac_cs_n`).
- Uses a valid/ready handshake so the sample rate is throttled by frame length.

---
 rtl/dac_spi_serializer.sv | 163 ++++++++++++++++
 tb/tb_dac_spi_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dac_spi_serializer
//  Purpose  : Takes one signed sample per valid/ready handshake, optionally
//             converts it to offset binary, and shifts it MSB-first to a
//             serial DAC over an SPI mode-0 link (sclk idles low, data is
//             stable across the rising edge).
//  Revision : 1.0  initial release
// ============================================================================
module dac_spi_serializer #(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2,
    parameter int OFFSET_BIN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              dac_cs_n,
    output logic              busy,
    output logic              frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);

    localparam logic [DIV_W-1:0]  c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  c_DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0]  c_BIT_LAST = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0]  c_BIT_ONE  = BIT_W'(1);
    localparam logic [GAP_W-1:0]  c_GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [GAP_W-1:0]  c_GAP_ONE  = GAP_W'(1);
    // Flipping only the sign bit maps two's complement onto offset binary.
    localparam logic [DATA_W-1:0] c_MSB_MASK =
        (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    logic [DATA_W-1:0] r_shreg, w_shreg_nx;
    logic [DIV_W-1:0]  r_div,   w_div_nx;
    logic [BIT_W-1:0]  r_bit,   w_bit_nx;
    logic [GAP_W-1:0]  r_gap,   w_gap_nx;
    logic              r_sclk,  w_sclk_nx;
    logic              r_cs_n,  w_cs_n_nx;
    logic              r_busy,  w_busy_nx;
    logic              r_fdone, w_fdone_nx;
    logic [DATA_W-1:0] w_code;

    assign w_code       = sample ^ c_MSB_MASK;
    assign sample_ready = (r_state == S_IDLE) && reset;

    // MOSI is the shift register MSB itself, so it is registered and the
    // register is cleared when the frame ends to park the line low.
    assign dac_sclk   = r_sclk;
    assign dac_mosi   = r_shreg[DATA_W-1];
    assign dac_cs_n   = r_cs_n;
    assign busy       = r_busy;
    assign frame_done = r_fdone;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_shreg_nx = r_shreg;
        w_div_nx   = r_div;
        w_bit_nx   = r_bit;
        w_gap_nx   = r_gap;
        w_sclk_nx  = r_sclk;
        w_cs_n_nx  = r_cs_n;
        w_busy_nx  = r_busy;
        w_fdone_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (sample_valid && sample_ready) begin
                    w_state_nx = S_SHIFT;
                    w_shreg_nx = w_code;
                    w_cs_n_nx  = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_sclk_nx  = 1'b0;
                    w_div_nx   = '0;
                    w_bit_nx   = '0;
                end
            end

            S_SHIFT: begin
                if (r_div == c_DIV_LAST) begin
                    w_div_nx = '0;
                    if (!r_sclk) begin
                        // Rising edge: DAC samples the bit already on MOSI.
                        w_sclk_nx = 1'b1;
                        w_bit_nx  = r_bit + c_BIT_ONE;
                    end else if (r_bit == c_BIT_LAST) begin
                        // High phase of the final bit is over: close the frame.
                        w_sclk_nx  = 1'b0;
                        w_state_nx = S_GAP;
                        w_cs_n_nx  = 1'b1;
                        w_shreg_nx = '0;
                        w_fdone_nx = 1'b1;
                        w_gap_nx   = '0;
                    end else begin
                        // Falling edge: present the next bit.
                        w_sclk_nx  = 1'b0;
                        w_shreg_nx = {r_shreg[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    w_div_nx = r_div + c_DIV_ONE;
                end
            end

            S_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                    w_gap_nx   = '0;
                end else begin
                    w_gap_nx = r_gap + c_GAP_ONE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_fdone <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_shreg <= w_shreg_nx;
            r_div   <= w_div_nx;
            r_bit   <= w_bit_nx;
            r_gap   <= w_gap_nx;
            r_sclk  <= w_sclk_nx;
            r_cs_n  <= w_cs_n_nx;
            r_busy  <= w_busy_nx;
            r_fdone <= w_fdone_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dac_spi_serializer
//  Purpose  : Bench for dac_spi_serializer. Instance A uses the default
//             parameters, instance B uses OFFSET_BIN=0, CLK_DIV=1, CS_GAP=1.
//             An SPI receiver model rebuilds each frame from the pins.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dac_spi_serializer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n = 2'b00;
    logic [1:0]  vld   = 2'b00;
    logic [1:0]  ready, sclk, mosi, cs_n, busy, fd;
    logic [15:0] smp [2];

    dac_spi_serializer #(.DATA_W(16), .CLK_DIV(2), .CS_GAP(2), .OFFSET_BIN(1)) u_dut_a (
        .clk(clk), .reset(rst_n[0]), .sample(smp[0]), .sample_valid(vld[0]),
        .sample_ready(ready[0]), .dac_sclk(sclk[0]), .dac_mosi(mosi[0]),
        .dac_cs_n(cs_n[0]), .busy(busy[0]), .frame_done(fd[0])
    );

    dac_spi_serializer #(.DATA_W(16), .CLK_DIV(1), .CS_GAP(1), .OFFSET_BIN(0)) u_dut_b (
        .clk(clk), .reset(rst_n[1]), .sample(smp[1]), .sample_valid(vld[1]),
        .sample_ready(ready[1]), .dac_sclk(sclk[1]), .dac_mosi(mosi[1]),
        .dac_cs_n(cs_n[1]), .busy(busy[1]), .frame_done(fd[1])
    );

    typedef struct {
        logic [15:0] word;
        int          len;
        int          rises;
        int          pmin;
        int          pmax;
        logic        fd_end;
    } frame_t;

    frame_t      fq[$];
    int          gq[$];
    int          hq[$];
    logic [15:0] exq[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // SPI receiver model: captures MOSI on rising SCLK while CS is low.
    logic [15:0] m_word [2];
    int          m_len [2], m_rises [2], m_gap [2], m_last [2], m_pmin [2], m_pmax [2];
    logic        m_pcs [2], m_psclk [2], m_pbusy [2];
    int          fd_cnt [2];
    int          bad_rise = 0;
    int          bad_ready = 0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_word[k] = '0; m_len[k] = 0; m_rises[k] = 0; m_gap[k] = 0;
            m_last[k] = 0; m_pmin[k] = 0; m_pmax[k] = 0;
            m_pcs[k] = 1'b1; m_psclk[k] = 1'b0; m_pbusy[k] = 1'b0; fd_cnt[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cs_n[k] === 1'b0) begin
                if (m_pcs[k]) begin
                    m_word[k] = '0; m_len[k] = 0; m_rises[k] = 0; m_gap[k] = 0;
                    m_pmin[k] = 1000; m_pmax[k] = 0;
                end
                m_len[k]++;
                if (sclk[k] && !m_psclk[k]) begin
                    m_word[k] = {m_word[k][14:0], mosi[k]};
                    m_rises[k]++;
                    if (m_rises[k] > 1) begin
                        if (cyc - m_last[k] < m_pmin[k]) m_pmin[k] = cyc - m_last[k];
                        if (cyc - m_last[k] > m_pmax[k]) m_pmax[k] = cyc - m_last[k];
                    end
                    m_last[k] = cyc;
                end
                if (ready[k]) bad_ready++;
            end else if (cs_n[k] === 1'b1) begin
                if (!m_pcs[k])
                    fq.push_back('{m_word[k], m_len[k], m_rises[k], m_pmin[k], m_pmax[k], fd[k]});
                if (sclk[k] && !m_psclk[k]) bad_rise++;
                if (busy[k]) m_gap[k]++;
            end
            if (!busy[k] && m_pbusy[k]) gq.push_back(m_gap[k]);
            if (fd[k]) fd_cnt[k]++;
            m_pcs[k]   = cs_n[k];
            m_psclk[k] = sclk[k];
            m_pbusy[k] = busy[k];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [15:0] d);
        int i = 0;
        while (!ready[k] && i < 500) begin
            tick();
            i++;
        end
        if (!ready[k]) check_eq("ready_timeout", 0, 1);
        hq.push_back(cyc);
        smp[k] = d;
        vld[k] = 1'b1;
        tick();
        vld[k] = 1'b0;
    endtask

    task automatic wait_frame(output frame_t f, output int gap);
        int i = 0;
        while (gq.size() == 0 && i < 1000) begin
            tick();
            i++;
        end
        if (gq.size() == 0 || fq.size() == 0) begin
            check_eq("frame_timeout", 0, 1);
            f   = '{16'h0, 0, 0, 0, 0, 1'b0};
            gap = 0;
        end else begin
            f   = fq.pop_front();
            gap = gq.pop_front();
        end
    endtask

    // Full frame check against the expected DAC word and frame geometry.
    task automatic frame_check(input int k, input logic [15:0] d, input string tag);
        frame_t      f;
        int          gap;
        logic [15:0] exp_word;
        int          div   = (k == 0) ? 2 : 1;
        int          csgap = (k == 0) ? 2 : 1;
        exp_word = (k == 0) ? (d ^ 16'h8000) : d;
        send(k, d);
        wait_frame(f, gap);
        check_eq({tag, "_word"},  32'(f.word),  32'(exp_word));
        check_eq({tag, "_cslen"}, f.len,        2 * 16 * div);
        check_eq({tag, "_rises"}, f.rises,      16);
        check_eq({tag, "_fd"},    32'(f.fd_end), 1);
        check_eq({tag, "_gap"},   gap,          csgap);
        check_eq({tag, "_per"},   {f.pmin[15:0], f.pmax[15:0]}, {16'(2 * div), 16'(2 * div)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          fdb;
        int          i;
        int          cnt;
        frame_t      f;
        int          gap;
        logic [15:0] d;

        smp[0] = '0;
        smp[1] = '0;
        repeat (2) tick();
        rst_n = 2'b11;
        repeat (3) tick();

        // Reset held low for three cycles while idle.
        rst_n[0] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            check_eq("reset_outputs", {cs_n[0], sclk[0], mosi[0], ready[0], busy[0], fd[0]}, 6'b100000);
        end
        rst_n[0] = 1'b1;
        tick();
        check_eq("ready_after_reset", 32'(ready[0]), 1);

        // Default frame and two back-to-back frames.
        fdb = fd_cnt[0];
        frame_check(0, 16'h7fff, "f7fff");
        check_eq("single_fd_pulse", fd_cnt[0] - fdb, 1);
        hq.delete();
        frame_check(0, 16'h8000, "f8000");
        frame_check(0, 16'h0101, "f0101");
        check_eq("hs_spacing_a", hq[1] - hq[0], 67);

        // Random words.
        for (int r = 0; r < 6; r++) begin
            d = 16'($urandom);
            frame_check(0, d, "rand");
        end

        // Valid held high while the sample changes every cycle.
        hq.delete();
        exq.delete();
        cnt = 0;
        smp[0] = 16'($urandom);
        vld[0] = 1'b1;
        for (i = 0; i < 400 && cnt < 3; i++) begin
            if (ready[0]) begin
                hq.push_back(cyc);
                exq.push_back(smp[0] ^ 16'h8000);
                cnt++;
            end
            tick();
            smp[0] = smp[0] + 16'd1;
        end
        vld[0] = 1'b0;
        check_eq("stream_hs_count", cnt, 3);
        for (int r = 0; r < cnt; r++) begin
            wait_frame(f, gap);
            check_eq("stream_word", 32'(f.word), 32'(exq[r]));
        end
        if (cnt == 3) begin
            check_eq("stream_spacing1", hq[1] - hq[0], 67);
            check_eq("stream_spacing2", hq[2] - hq[1], 67);
        end

        // Reset after the fifth rising SCLK edge of a frame.
        send(0, 16'($urandom));
        i = 0;
        while (m_rises[0] != 5 && i < 500) begin
            tick();
            i++;
        end
        check_eq("midreset_reach5", m_rises[0], 5);
        fdb = fd_cnt[0];
        rst_n[0] = 1'b0;
        tick();
        check_eq("midreset_outputs", {cs_n[0], sclk[0], mosi[0], busy[0], fd[0], ready[0]}, 6'b100000);
        tick();
        rst_n[0] = 1'b1;
        repeat (6) tick();
        check_eq("midreset_no_fd", fd_cnt[0] - fdb, 0);
        fq.delete();
        gq.delete();
        frame_check(0, 16'h2000, "after_reset");

        // Second configuration: no offset conversion, fast clock, short gap.
        hq.delete();
        frame_check(1, 16'h2000, "b2000");
        d = 16'($urandom);
        frame_check(1, d, "brand");
        check_eq("hs_spacing_b", hq[1] - hq[0], 34);

        check_eq("no_sclk_rise_cs_high", bad_rise, 0);
        check_eq("no_ready_in_frame", bad_ready, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
